// File: rtl/fib_term_fifo_if.sv
// fib_term_fifo_if: valid/ready bus for terms entering and indexed terms leaving fib_term_fifo (master = generator/consumer side, slave = buffer)
interface fib_term_fifo_if #(parameter int WIDTH = 64);
  logic in_valid;
  logic [WIDTH-1:0] in_data;
  logic in_ready;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic [31:0] out_index;
  logic out_ready;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_index);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_index);
endinterface

// File: rtl/fib_term_fifo.sv
// fib_term_fifo: index-tagged Fibonacci term buffer; ports clk, reset (async low), flush, bus (fib_term_fifo_if.slave), level, drop_err, wrap_err; FIB_WRAP_CHECK_EN enables the wrap checker
module fib_term_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  fib_term_fifo_if.slave bus,
  output logic [$clog2(DEPTH):0] level,
  output logic drop_err,
  output logic wrap_err
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] push_idx;
  logic [WIDTH+31:0] mem [DEPTH];
  logic full, empty, push, pop;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign empty = wr_ptr == rd_ptr;
  assign push = bus.in_valid && !full && !flush;
  assign pop = bus.out_ready && !empty && !flush;
  assign bus.in_ready = !full;
  assign bus.out_valid = !empty;
  assign {bus.out_index, bus.out_data} = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      push_idx <= '0;
      drop_err <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      push_idx <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (bus.in_valid) push_idx <= push_idx + 32'd1;
      if (bus.in_valid && full) drop_err <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {push_idx, bus.in_data};
`ifdef FIB_WRAP_CHECK_EN
  logic [WIDTH-1:0] prev1, prev2, sum;
  logic [1:0] hist;
  assign sum = prev1 + prev2;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prev1 <= '0;
      prev2 <= '0;
      hist <= '0;
      wrap_err <= 1'b0;
    end else if (flush) begin
      prev1 <= '0;
      prev2 <= '0;
      hist <= '0;
      wrap_err <= 1'b0;
    end else if (bus.in_valid) begin
      if (hist == 2'd2 && (bus.in_data != sum || bus.in_data < prev1)) wrap_err <= 1'b1;
      prev2 <= prev1;
      prev1 <= bus.in_data;
      if (hist != 2'd2) hist <= hist + 2'd1;
    end
`else
  assign wrap_err = 1'b0;
`endif
endmodule

// File: doc/fib_term_fifo.md
# fib_term_fifo

Buffers the stream of Fibonacci terms produced by the upstream generator stage and hands them to downstream consumers over a valid/ready interface. Each stored term is tagged with its sequence index. A sticky error flags any term that arrives while the buffer is full, so the generator can run without per-term backpressure. An optional checker flags arithmetic wrap-around in the incoming sequence.

## Interface
- WIDTH, 64, term width in bits; must match the generator's output width.
- DEPTH, 8, number of buffer entries; power of two, at least 2.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of the buffer, index counter and flags.
- in_valid  input  1  a new term is present on in_data this cycle.
- in_data  input  WIDTH  incoming term.
- in_ready  output  1  buffer can accept; equals not-full.
- out_valid  output  1  head entry is available.
- out_data  output  WIDTH  head term.
- out_index  output  32  sequence index of the head term (0 = first term after reset/flush).
- out_ready  input  1  consumer accepts the head entry.
- level  output  $clog2(DEPTH)+1  number of occupied entries.
- drop_err  output  1  sticky: a term was presented while the buffer was full.
- wrap_err  output  1  sticky: wrap-around detected (only with FIB_WRAP_CHECK_EN; otherwise tied 0).

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry is {index[31:0], term[WIDTH-1:0]}.
- Pointers are $clog2(DEPTH)+1 bits wide. Full means the MSBs differ and the remaining bits are equal; empty means the pointers are equal.
- Push: in_valid && in_ready. Writes {push_idx, in_data} at wr_ptr, then increments wr_ptr and push_idx.
- push_idx is a 32-bit counter that wraps modulo 2^32.
- Drop: in_valid && !in_ready. The term is discarded, push_idx still increments, and drop_err is set. Downstream therefore sees a gap in out_index.
- Pop: out_valid && out_ready. Increments rd_ptr.
- out_data and out_index are read combinationally from the entry at rd_ptr. out_valid = !empty.
- Push and pop in the same cycle: both take effect and level is unchanged.
- When full, in_ready is 0 even if a pop occurs in the same cycle. There is no pass-through.
- When empty, there is no bypass: a pushed term becomes visible on the next cycle.
- flush:
  - Clears the pointers, push_idx, drop_err, wrap_err and the wrap-check history.
  - Takes priority over a push or pop in the same cycle; those are ignored.
  - in_data in the flush cycle is neither stored nor counted.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_index=0, level=0, drop_err=0, wrap_err=0. Buffer contents are don't-care.
- Reset is asserted asynchronously and released synchronously by the integration.
- Assertion mid-operation clears everything immediately; in-flight entries are lost.
- Latency: a push at edge k gives out_valid=1 with that term visible after edge k, i.e. one cycle from the in_valid cycle.
- level, in_ready and out_valid update on the same edge as the push/pop that changes them.
- in_ready is registered-equivalent: it is derived only from the pointers, with no combinational path from in_valid or out_ready.
- Throughput: one push and one pop per cycle.

## Configuration
- FIB_WRAP_CHECK_EN defined:
  - Keeps registers prev1 and prev2 holding the last two accepted or dropped terms, plus a 2-bit history count.
  - Once two terms are in history, an incoming term with in_data != prev1 + prev2 (WIDTH-bit sum) or in_data < prev1 sets wrap_err (sticky).
  - The check applies to every presented term, including dropped ones, so history stays aligned with the generator.
- FIB_WRAP_CHECK_EN undefined: the checker logic is absent and wrap_err is constant 0.

## Test plan
- Fill and drain: push terms 0,1,1,2,3,5,8,13 (DEPTH=8) with out_ready=0 -> in_ready=0 and level=8 after the 8th push. Then out_ready=1 for 8 cycles -> out_data 0..13 in order, out_index 0..7, then out_valid=0.
- Overflow: with the buffer full, present term 21 -> drop_err=1 and stays 1. Draining yields indices 0..7. Pushing 34 next stores it with out_index=9.
- Simultaneous push/pop at level 3 for 10 cycles -> level stays 3 and the output order matches the input order.
- flush with level=5, drop_err=1 and in_valid=1 in the same cycle -> next cycle level=0, out_valid=0, drop_err=0. The next push gets out_index=0.
- Async reset: assert reset low mid-stream between clock edges -> outputs take their reset values immediately, with no clock edge needed.
- With FIB_WRAP_CHECK_EN and WIDTH=8, stream the sequence through 233 then 121 (the 8-bit wrap of 377) -> wrap_err=1. Without the macro, wrap_err=0 throughout.
